// File: rtl/acondicionar_botones.sv
// Conditions four raw direction push-buttons into clean one-cycle move requests.
// Each channel: polarity fix -> 2-flop synchronizer -> debounce -> edge pulse with hold-to-repeat.
// Ports:
//   clk, reset                       : system clock, asynchronous active-high reset
//   btn_arriba/abajo/derecha/izquierda : raw asynchronous bouncing pins
//   arriba/abajo/derecha/izquierda   : registered one-cycle move-request pulses
//   presionado[3:0]                  : debounced pressed level {arriba, abajo, derecha, izquierda}
module acondicionar_botones #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 5000000,
  parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_arriba,
  input  logic       btn_abajo,
  input  logic       btn_derecha,
  input  logic       btn_izquierda,
  output logic       arriba,
  output logic       abajo,
  output logic       derecha,
  output logic       izquierda,
  output logic [3:0] presionado
);

  localparam int CW   = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int TW   = (TMAX < 1) ? 1 : $clog2(TMAX + 1);

  localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  // Timers are loaded with N-1 on the pulse edge so the next pulse lands exactly N edges later.
  localparam logic [TW-1:0] DELAY_LOAD = TW'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
  localparam logic [TW-1:0] RATE_LOAD  = TW'((REPEAT_RATE > 0) ? REPEAT_RATE - 1 : 0);

  typedef enum logic [1:0] {REPOSO, RETARDO, REPETIR} estado_t;

  logic [3:0] btn_act;
  logic [3:0] sync1_q;
  logic [3:0] sync2_q;
  logic [3:0] est_w;
  logic [3:0] pulso_w;

  // Polarity is normalised before the synchronizer so everything downstream is active-high.
  assign btn_act = {btn_arriba, btn_abajo, btn_derecha, btn_izquierda} ^ {4{BTN_ACTIVE_LOW}};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_act;
      sync2_q <= sync1_q;
    end
  end

  for (genvar ch = 0; ch < 4; ch++) begin : g_canal
    logic          est_q;
    logic          est_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [TW-1:0] tmr_q;
    logic          inh_q;
    logic          pulso_q;
    estado_t       estado_q;
    logic          subida;
    logic          bajada;

    // Debounce: counter runs only while the sample disagrees with the stable level.
    always_comb begin
      est_d = est_q;
      cnt_d = '0;
      if (sync2_q[ch] != est_q) begin
        if (cnt_q == CNT_LAST) begin
          est_d = ~est_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    // Edges are taken from the next-state value so the pulse registers on the same edge as est.
    assign subida = ~est_q & est_d;
    assign bajada = est_q & ~est_d;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        est_q    <= 1'b0;
        cnt_q    <= '0;
        tmr_q    <= '0;
        inh_q    <= 1'b0;
        pulso_q  <= 1'b0;
        estado_q <= REPOSO;
      end else begin
        est_q   <= est_d;
        cnt_q   <= cnt_d;
        pulso_q <= 1'b0;
        if (bajada) begin
          estado_q <= REPOSO;
          tmr_q    <= '0;
          inh_q    <= 1'b0;
        end else begin
          case (estado_q)
            REPOSO: begin
              if (subida) begin
                pulso_q <= 1'b1;
                tmr_q   <= DELAY_LOAD;
                if (REPEAT_DELAY == 0) begin
                  estado_q <= REPETIR;
                  inh_q    <= 1'b1;
                end else begin
                  estado_q <= RETARDO;
                end
              end
            end
            RETARDO: begin
              if (tmr_q == '0) begin
                pulso_q  <= 1'b1;
                estado_q <= REPETIR;
                if (REPEAT_RATE == 0) begin
                  inh_q <= 1'b1;
                end else begin
                  tmr_q <= RATE_LOAD;
                end
              end else begin
                tmr_q <= tmr_q - 1'b1;
              end
            end
            REPETIR: begin
              if (!inh_q) begin
                if (tmr_q == '0) begin
                  pulso_q <= 1'b1;
                  tmr_q   <= RATE_LOAD;
                end else begin
                  tmr_q <= tmr_q - 1'b1;
                end
              end
            end
            default: begin
              estado_q <= REPOSO;
              tmr_q    <= '0;
              inh_q    <= 1'b0;
            end
          endcase
        end
      end
    end

    assign est_w[ch]   = est_q;
    assign pulso_w[ch] = pulso_q;
  end

  assign presionado = est_w;
  assign arriba     = pulso_w[3];
  assign abajo      = pulso_w[2];
  assign derecha    = pulso_w[1];
  assign izquierda  = pulso_w[0];

endmodule
